wb_master_arb: RTL and testbench
================================

WB_MASTER_ARB -- requirements
Module: wb_master_arb

Interface
REQ-001 SHALL have parameter N_CH, default 3, number of master channels (2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width; SW = DW/8 select width.
REQ-004 SHALL have parameter TIMEOUT, default 255, bus-timeout cycles; 0 disables the timeout.
REQ-005 SHALL have port i_clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port i_reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports i_m_cyc  in  N_CH and i_m_we  in  N_CH; per-channel cycle and write enable.
REQ-008 SHALL have ports i_m_stb  in  N_CH*SW, i_m_addr  in  N_CH*AW, i_m_dat  in  N_CH*DW; channel k occupies slice k.
REQ-009 SHALL have ports o_m_ack  out  N_CH and o_m_err  out  N_CH; per-channel ack and error.
REQ-010 SHALL have port o_m_dat  out  DW; i_wb_dat broadcast to all channels.
REQ-011 SHALL have port o_grant  out  N_CH; one-hot current owner, all zero when idle.
REQ-012 SHALL have ports o_wb_cyc, o_wb_we (1), o_wb_stb (SW), o_wb_addr (AW), o_wb_dat (DW) out, and i_wb_dat (DW), i_wb_ack, i_wb_err (1) in; slave side.

Function
REQ-013 SHALL implement states IDLE, BUSY and DRAIN.
REQ-014 In IDLE with any i_m_cyc high, SHALL register the winner into o_grant and enter BUSY on the next edge (one-cycle arbitration latency).
REQ-015 In BUSY, SHALL drive slave outputs combinationally from the granted channel; in IDLE/DRAIN o_wb_cyc, o_wb_stb, o_wb_we SHALL be 0 and o_wb_addr, o_wb_dat 0.
REQ-016 SHALL hold the grant while the owner keeps i_m_cyc high (bus lock); other requests SHALL wait.
REQ-017 When the owner drops i_m_cyc in BUSY, SHALL clear o_grant and return to IDLE on that edge; re-grant SHALL occur no earlier than the following edge.
REQ-018 SHALL route i_wb_ack/i_wb_err only to the owner's o_m_ack/o_m_err, combinationally, in BUSY only; in IDLE/DRAIN they SHALL be ignored.
REQ-019 On simultaneous i_wb_ack and i_wb_err, SHALL assert only o_m_err.
REQ-020 Timeout counter SHALL clear on entering BUSY and on any ack/err, and increment each BUSY cycle with o_wb_cyc and any o_wb_stb bit high.
REQ-021 When the counter reaches TIMEOUT (TIMEOUT>0), SHALL pulse the owner's o_m_err for one cycle and enter DRAIN.
REQ-022 In DRAIN, SHALL keep o_grant and wait until owner drops i_m_cyc, then enter IDLE.
REQ-023 Counter width SHALL be sufficient for TIMEOUT without wrap-around; it SHALL saturate, never wrap.
REQ-024 Requests appearing and disappearing within IDLE before an edge SHALL not be granted.

Reset
REQ-025 Asserting i_reset SHALL immediately force IDLE, o_grant = 0, timeout counter = 0, round-robin pointer = 0.
REQ-026 During and after reset, all outputs SHALL be 0; reset mid-transaction SHALL drop o_wb_cyc without ack/err to any channel.

Configuration
REQ-027 With WB_ARB_RR_EN defined, SHALL arbitrate round-robin: search starts at pointer; on leaving BUSY/DRAIN with owner k, pointer becomes (k+1) mod N_CH.
REQ-028 Without WB_ARB_RR_EN, SHALL arbitrate fixed priority, lowest index wins; no pointer register exists.

Verification
REQ-029 Single request: ch1 cyc/stb=4'hF addr 0x100, slave acks after 2 cycles -> o_grant=3'b010 one cycle after cyc, o_m_ack[1] aligned with i_wb_ack, o_m_dat=i_wb_dat.
REQ-030 Contention: ch0 and ch2 raise cyc together -> fixed: ch0 granted first; RR from reset: ch0, then ch2 after ch0 releases, then ch0 again on repeat.
REQ-031 Lock: ch2 owns, ch0 requests mid-burst of 4 acks -> ch0 not granted until ch2 drops cyc; one IDLE cycle between grants.
REQ-032 Timeout: TIMEOUT=4, slave never responds -> o_m_err owner pulse after 4 strobe cycles, o_wb_cyc=0 in DRAIN, IDLE after owner drops cyc.
REQ-033 Ack+err same cycle -> o_m_err=1, o_m_ack=0 for owner; non-owner outputs 0.
REQ-034 Reset asserted asynchronously mid-transfer -> o_wb_cyc and o_grant 0 before next clock edge; normal grant after release.

Source files
------------

// File: rtl/wb_master_arb.sv
// Wishbone N-channel master arbiter with bus lock, bus timeout and DRAIN recovery.
// Define WB_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module wb_master_arb #(
  parameter int N_CH    = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [N_CH-1:0]           i_m_cyc,
  input  logic [N_CH-1:0]           i_m_we,
  input  logic [N_CH*(DW/8)-1:0]    i_m_stb,
  input  logic [N_CH*AW-1:0]        i_m_addr,
  input  logic [N_CH*DW-1:0]        i_m_dat,
  output logic [N_CH-1:0]           o_m_ack,
  output logic [N_CH-1:0]           o_m_err,
  output logic [DW-1:0]             o_m_dat,
  output logic [N_CH-1:0]           o_grant,
  output logic                      o_wb_cyc,
  output logic                      o_wb_we,
  output logic [DW/8-1:0]           o_wb_stb,
  output logic [AW-1:0]             o_wb_addr,
  output logic [DW-1:0]             o_wb_dat,
  input  logic [DW-1:0]             i_wb_dat,
  input  logic                      i_wb_ack,
  input  logic                      i_wb_err
);

  localparam int SW = DW / 8;
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX = (TIMEOUT > 0) ? CW'(TIMEOUT) : '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [N_CH-1:0] grant;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   cnt;
  logic            to_err;

  logic            win_vld;
  logic [IW-1:0]   win_idx;

  logic            sel_cyc;
  logic            sel_we;
  logic [SW-1:0]   sel_stb;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_dat;

  logic            busy;
  logic            stb_act;

  // Owner's request lines; everything downstream keys off the registered owner index.
  always_comb begin
    sel_cyc  = 1'b0;
    sel_we   = 1'b0;
    sel_stb  = '0;
    sel_addr = '0;
    sel_dat  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (owner == IW'(i)) begin
        sel_cyc  = i_m_cyc[i];
        sel_we   = i_m_we[i];
        sel_stb  = i_m_stb[i*SW +: SW];
        sel_addr = i_m_addr[i*AW +: AW];
        sel_dat  = i_m_dat[i*DW +: DW];
      end
    end
  end

`ifdef WB_ARB_RR_EN
  localparam logic [IW:0] NCH_W = (IW+1)'(N_CH);

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_nxt;
  logic [N_CH-1:0] rot;
  logic [IW:0]     sum;
  logic [IW:0]     own_p1;

  // Rotate requests so bit 0 is the pointer position, then map the first hit back.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    rot     = N_CH'({i_m_cyc, i_m_cyc} >> ptr);
    for (int i = 0; i < N_CH; i++) begin
      if (!win_vld && rot[i]) begin
        win_vld = 1'b1;
        sum     = {1'b0, ptr} + (IW+1)'(i);
        if (sum >= NCH_W) sum = sum - NCH_W;
        win_idx = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    own_p1  = {1'b0, owner} + 1'b1;
    ptr_nxt = (own_p1 == NCH_W) ? '0 : own_p1[IW-1:0];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr <= '0;
    end else if ((state == BUSY || state == DRAIN) && !sel_cyc) begin
      ptr <= ptr_nxt;
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!win_vld && i_m_cyc[i]) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
  end
`endif

  assign busy    = (state == BUSY);
  assign stb_act = o_wb_cyc && (|o_wb_stb);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      grant  <= '0;
      owner  <= '0;
      cnt    <= '0;
      to_err <= 1'b0;
    end else begin
      to_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state <= BUSY;
            grant <= {{(N_CH-1){1'b0}}, 1'b1} << win_idx;
            owner <= win_idx;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (!sel_cyc) begin
            state <= IDLE;
            grant <= '0;
          end else if (i_wb_ack || i_wb_err) begin
            cnt <= '0;
          end else if (stb_act) begin
            // The edge that brings the count to TIMEOUT also raises the error pulse.
            if (TIMEOUT != 0 && cnt == TO_LAST) begin
              state  <= DRAIN;
              to_err <= 1'b1;
            end
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!sel_cyc) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign o_grant   = grant;
  assign o_wb_cyc  = busy & sel_cyc;
  assign o_wb_we   = busy & sel_we;
  assign o_wb_stb  = busy ? sel_stb  : '0;
  assign o_wb_addr = busy ? sel_addr : '0;
  assign o_wb_dat  = busy ? sel_dat  : '0;

  // Error wins over a coincident ack; the timeout pulse lands in the first DRAIN cycle.
  assign o_m_ack = (busy && i_wb_ack && !i_wb_err) ? grant : '0;
  assign o_m_err = ((busy && i_wb_err) || to_err) ? grant : '0;
  assign o_m_dat = i_reset ? '0 : i_wb_dat;

endmodule

// File: tb/tb_wb_master_arb.sv
// Directed bench for wb_master_arb (3 channels, TIMEOUT=4); expectations follow WB_ARB_RR_EN when defined.
module tb_wb_master_arb;

`ifdef WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  m_cyc, m_we;
  logic [11:0] m_stb;
  logic [95:0] m_addr, m_dat;
  logic [2:0]  m_ack, m_err, grant;
  logic [31:0] m_dat_out;
  logic        wb_cyc, wb_we;
  logic [3:0]  wb_stb;
  logic [31:0] wb_addr, wb_dat_o, wb_dat_i;
  logic        wb_ack, wb_err;

  int n_tests = 0;
  int n_fail  = 0;

  wb_master_arb #(.N_CH(3), .AW(32), .DW(32), .TIMEOUT(4)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_m_cyc   (m_cyc),
    .i_m_we    (m_we),
    .i_m_stb   (m_stb),
    .i_m_addr  (m_addr),
    .i_m_dat   (m_dat),
    .o_m_ack   (m_ack),
    .o_m_err   (m_err),
    .o_m_dat   (m_dat_out),
    .o_grant   (grant),
    .o_wb_cyc  (wb_cyc),
    .o_wb_we   (wb_we),
    .o_wb_stb  (wb_stb),
    .o_wb_addr (wb_addr),
    .o_wb_dat  (wb_dat_o),
    .i_wb_dat  (wb_dat_i),
    .i_wb_ack  (wb_ack),
    .i_wb_err  (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    m_cyc    = 3'b000;
    m_we     = 3'b010;
    m_stb    = 12'hFFF;
    m_addr   = {32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
    m_dat    = {32'h0000_00D2, 32'h0000_00D1, 32'h0000_00D0};
    wb_dat_i = 32'h1234_5678;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;

    // Reset state, with a request pending
    tick();
    check("rst_grant", 64'(grant), 64'(3'b000));
    check("rst_cyc",   64'(wb_cyc), 64'(1'b0));
    check("rst_mdat",  64'(m_dat_out), 64'(32'h0));
    m_cyc = 3'b010;
    tick();
    check("rst_hold_grant", 64'(grant), 64'(3'b000));
    m_cyc = 3'b000;
    rst   = 1'b0;

    // Contention ch0+ch2
    tick();
    m_cyc = 3'b101;
    tick();
    check("cont_first", 64'(grant), 64'(3'b001));
    m_cyc = 3'b100;
    tick();
    check("cont_gap", 64'(grant), 64'(3'b000));
    tick();
    check("cont_second", 64'(grant), 64'(3'b100));
    m_cyc = 3'b000;
    tick();
    check("cont_rel", 64'(grant), 64'(3'b000));
    m_cyc = 3'b101;
    tick();
    check("cont_repeat", 64'(grant), 64'(3'b001));
    m_cyc = 3'b100;
    tick();
    check("cont_gap2", 64'(grant), 64'(3'b000));
    m_cyc = 3'b101;
    tick();
    check("cont_policy", 64'(grant), RR ? 64'(3'b100) : 64'(3'b001));
    m_cyc = 3'b000;
    tick();
    tick();
    check("cont_idle", 64'(grant), 64'(3'b000));

    // Single request on ch1, slave acks in the second bus cycle
    m_cyc = 3'b010;
    #1 check("single_latency", 64'(grant), 64'(3'b000));
    tick();
    check("single_grant", 64'(grant), 64'(3'b010));
    check("single_cyc",   64'(wb_cyc), 64'(1'b1));
    check("single_addr",  64'(wb_addr), 64'(32'h100));
    check("single_stb",   64'(wb_stb), 64'(4'hF));
    check("single_we",    64'(wb_we), 64'(1'b1));
    check("single_wdat",  64'(wb_dat_o), 64'(32'hD1));
    tick();
    wb_ack   = 1'b1;
    wb_dat_i = 32'hCAFE_F00D;
    #1 check("single_ack", 64'(m_ack), 64'(3'b010));
    check("single_rdat", 64'(m_dat_out), 64'(32'hCAFE_F00D));
    check("single_noerr", 64'(m_err), 64'(3'b000));
    tick();
    wb_ack = 1'b0;
    m_cyc  = 3'b000;
    #1 check("single_drop_cyc", 64'(wb_cyc), 64'(1'b0));
    tick();
    check("single_release", 64'(grant), 64'(3'b000));
    wb_ack = 1'b1;
    #1 check("idle_ack_ignored", 64'(m_ack), 64'(3'b000));
    wb_ack = 1'b0;

    // Ack and err together
    tick();
    m_cyc = 3'b010;
    tick();
    check("ae_grant", 64'(grant), 64'(3'b010));
    wb_ack = 1'b1;
    wb_err = 1'b1;
    #1 check("ae_err", 64'(m_err), 64'(3'b010));
    check("ae_ack", 64'(m_ack), 64'(3'b000));
    wb_ack = 1'b0;
    wb_err = 1'b0;
    m_cyc  = 3'b000;
    tick();
    tick();

    // Bus lock: ch2 owns through 4 acks while ch0 waits
    m_cyc = 3'b100;
    tick();
    check("lock_grant", 64'(grant), 64'(3'b100));
    check("lock_addr", 64'(wb_addr), 64'(32'h200));
    m_cyc = 3'b101;
    for (int i = 0; i < 4; i++) begin
      wb_ack = 1'b1;
      #1 check("lock_ack", 64'(m_ack), 64'(3'b100));
      tick();
      check("lock_hold", 64'(grant), 64'(3'b100));
    end
    wb_ack = 1'b0;
    m_cyc  = 3'b001;
    tick();
    check("lock_gap", 64'(grant), 64'(3'b000));
    tick();
    check("lock_next", 64'(grant), 64'(3'b001));
    check("lock_next_addr", 64'(wb_addr), 64'(32'h0));
    m_cyc = 3'b000;
    tick();
    check("lock_idle", 64'(grant), 64'(3'b000));

    // Timeout with a silent slave
    m_cyc = 3'b001;
    tick();
    check("to_grant", 64'(grant), 64'(3'b001));
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("to_wait_err", 64'(m_err), 64'(3'b000));
      check("to_wait_cyc", 64'(wb_cyc), 64'(1'b1));
    end
    tick();
    check("to_err", 64'(m_err), 64'(3'b001));
    check("to_drain_cyc", 64'(wb_cyc), 64'(1'b0));
    check("to_drain_grant", 64'(grant), 64'(3'b001));
    tick();
    check("to_pulse_end", 64'(m_err), 64'(3'b000));
    check("to_drain_hold", 64'(grant), 64'(3'b001));
    wb_ack = 1'b1;
    #1 check("to_drain_ack", 64'(m_ack), 64'(3'b000));
    wb_ack = 1'b0;
    m_cyc  = 3'b000;
    tick();
    check("to_drain_exit", 64'(grant), 64'(3'b000));

    // Asynchronous reset mid-transfer
    m_cyc = 3'b100;
    tick();
    check("ar_grant", 64'(grant), 64'(3'b100));
    check("ar_cyc", 64'(wb_cyc), 64'(1'b1));
    #2 rst = 1'b1;
    wb_ack = 1'b1;
    #1 check("ar_cyc_drop", 64'(wb_cyc), 64'(1'b0));
    check("ar_grant_drop", 64'(grant), 64'(3'b000));
    check("ar_ack_drop", 64'(m_ack), 64'(3'b000));
    tick();
    rst    = 1'b0;
    wb_ack = 1'b0;
    tick();
    check("ar_regrant", 64'(grant), 64'(3'b100));
    m_cyc = 3'b000;
    tick();
    check("ar_final_idle", 64'(grant), 64'(3'b000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
